// File: rtl/mem_pkg.sv
// Shared definitions for the load/store unit: access-size encodings, the
// controller state type and small lane helpers for the big-endian,
// word-wide data memory (byte at the aligned address sits in bits [31:24]).
package mem_pkg;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;
  localparam logic [1:0] SIZE_BAD  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_READ  = 2'b01,
    ST_WRITE = 2'b10,
    ST_DONE  = 2'b11
  } lsu_state_e;

  // Bit position of the LSB of the lane addressed by (size, offset).
  // Big-endian: byte offset 0 is the top byte, so the shift shrinks as the
  // offset grows.
  function automatic logic [4:0] lane_shift(input logic [1:0] size,
                                            input logic [1:0] offset);
    logic [4:0] sh;
    sh = 5'd0;
    case (size)
      SIZE_BYTE: sh = {2'b11 - offset, 3'b000};
      SIZE_HALF: sh = {~offset[1], 4'b0000};
      default:   sh = 5'd0;
    endcase
    return sh;
  endfunction

  // Natural alignment check; the illegal size encoding is never acceptable.
  function automatic logic access_ok(input logic [1:0] size,
                                     input logic [1:0] offset);
    logic ok;
    ok = 1'b0;
    case (size)
      SIZE_BYTE: ok = 1'b1;
      SIZE_HALF: ok = ~offset[0];
      SIZE_WORD: ok = (offset == 2'b00);
      default:   ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Combinational lane logic for the load/store unit.
//   word_i      : word read from memory
//   offset_i    : byte offset within the word (addr[1:0])
//   size_i      : access size encoding
//   signed_i    : sign-extend loads when 1
//   wdata_i     : store data (byte/half taken from the LSBs)
//   load_data_o : selected lane, extended to 32 bits
//   merged_o    : word_i with the addressed lane replaced by store data
module lsu_lane_align
  import mem_pkg::*;
(
  input  logic [31:0] word_i,
  input  logic [1:0]  offset_i,
  input  logic [1:0]  size_i,
  input  logic        signed_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] load_data_o,
  output logic [31:0] merged_o
);

  logic [4:0]  shift_s;
  logic [7:0]  byte_s;
  logic [15:0] half_s;

  // Pick the addressed byte and halfword out of the word.
  always_comb begin
    byte_s = 8'h00;
    case (offset_i)
      2'b00:   byte_s = word_i[31:24];
      2'b01:   byte_s = word_i[23:16];
      2'b10:   byte_s = word_i[15:8];
      2'b11:   byte_s = word_i[7:0];
      default: byte_s = 8'h00;
    endcase
    if (offset_i[1]) begin
      half_s = word_i[15:0];
    end else begin
      half_s = word_i[31:16];
    end
  end

  // Extend loads and merge store data into the read word.
  always_comb begin
    shift_s     = lane_shift(size_i, offset_i);
    load_data_o = 32'h0000_0000;
    merged_o    = word_i;
    case (size_i)
      SIZE_BYTE: begin
        load_data_o = {{24{signed_i & byte_s[7]}}, byte_s};
        merged_o    = (word_i & ~(32'h0000_00FF << shift_s)) |
                      ({24'h00_0000, wdata_i[7:0]} << shift_s);
      end
      SIZE_HALF: begin
        load_data_o = {{16{signed_i & half_s[15]}}, half_s};
        merged_o    = (word_i & ~(32'h0000_FFFF << shift_s)) |
                      ({16'h0000, wdata_i[15:0]} << shift_s);
      end
      SIZE_WORD: begin
        load_data_o = word_i;
        merged_o    = wdata_i;
      end
      default: begin
        load_data_o = 32'h0000_0000;
        merged_o    = word_i;
      end
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: initiator side of the big-endian, word-wide data memory.
// Accepts one request at a time, performs sub-word stores as
// read-modify-write, and returns extended load data with a one-cycle
// resp_valid pulse. All outputs are registered.
//   clk, reset      : clock and asynchronous active-high reset
//   req_*           : CPU request handshake and payload
//   resp_*          : completion pulse, load data, error flag
//   mem_*, MemRead, MemWrite, mem_read_data : data memory interface
module load_store_unit
  import mem_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int READ_WAIT  = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_store,
  input  logic [1:0]            req_size,
  input  logic                  req_signed,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [31:0]           req_wdata,
  output logic                  resp_valid,
  output logic [31:0]           resp_rdata,
  output logic                  resp_error,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic [31:0]           mem_write_data,
  output logic                  MemRead,
  output logic                  MemWrite,
  input  logic [31:0]           mem_read_data
);

  localparam logic [3:0] WAIT_INIT = 4'(READ_WAIT - 1);

  lsu_state_e            state_q;
  logic [3:0]            wait_q;
  logic [1:0]            offset_q;
  logic [1:0]            size_q;
  logic                  signed_q;
  logic                  store_q;
  logic [31:0]           wdata_q;

  logic                  req_ready_q;
  logic                  resp_valid_q;
  logic [31:0]           resp_rdata_q;
  logic                  resp_error_q;
  logic [ADDR_WIDTH-1:0] mem_address_q;
  logic [31:0]           mem_write_data_q;
  logic                  mem_read_q;
  logic                  mem_write_q;

  logic                  legal_s;
  logic [31:0]           load_data_s;
  logic [31:0]           merged_s;

  assign legal_s = access_ok(req_size, req_addr[1:0]);

  // Lane logic works on the live memory word so it can be captured on the
  // last READ edge.
  lsu_lane_align u_align (
    .word_i      (mem_read_data),
    .offset_i    (offset_q),
    .size_i      (size_q),
    .signed_i    (signed_q),
    .wdata_i     (wdata_q),
    .load_data_o (load_data_s),
    .merged_o    (merged_s)
  );

  // Controller FSM with registered request fields and outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q          <= ST_IDLE;
      wait_q           <= 4'd0;
      offset_q         <= 2'b00;
      size_q           <= SIZE_BYTE;
      signed_q         <= 1'b0;
      store_q          <= 1'b0;
      wdata_q          <= 32'h0000_0000;
      req_ready_q      <= 1'b1;
      resp_valid_q     <= 1'b0;
      resp_rdata_q     <= 32'h0000_0000;
      resp_error_q     <= 1'b0;
      mem_address_q    <= '0;
      mem_write_data_q <= 32'h0000_0000;
      mem_read_q       <= 1'b0;
      mem_write_q      <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (req_valid) begin
            req_ready_q   <= 1'b0;
            offset_q      <= req_addr[1:0];
            size_q        <= req_size;
            signed_q      <= req_signed;
            store_q       <= req_store;
            wdata_q       <= req_wdata;
            mem_address_q <= {req_addr[ADDR_WIDTH-1:2], 2'b00};
            if (!legal_s) begin
              // Bad requests never touch memory.
              state_q      <= ST_DONE;
              resp_valid_q <= 1'b1;
              resp_error_q <= 1'b1;
              resp_rdata_q <= 32'h0000_0000;
            end else if (req_store && (req_size == SIZE_WORD)) begin
              state_q          <= ST_WRITE;
              mem_write_q      <= 1'b1;
              mem_write_data_q <= req_wdata;
            end else begin
              state_q    <= ST_READ;
              mem_read_q <= 1'b1;
              wait_q     <= WAIT_INIT;
            end
          end else begin
            req_ready_q <= 1'b1;
          end
        end
        ST_READ: begin
          if (wait_q == 4'd0) begin
            mem_read_q <= 1'b0;
            if (store_q) begin
              state_q          <= ST_WRITE;
              mem_write_q      <= 1'b1;
              mem_write_data_q <= merged_s;
            end else begin
              state_q      <= ST_DONE;
              resp_valid_q <= 1'b1;
              resp_error_q <= 1'b0;
              resp_rdata_q <= load_data_s;
            end
          end else begin
            wait_q <= wait_q - 4'd1;
          end
        end
        ST_WRITE: begin
          mem_write_q  <= 1'b0;
          state_q      <= ST_DONE;
          resp_valid_q <= 1'b1;
          resp_error_q <= 1'b0;
          resp_rdata_q <= 32'h0000_0000;
        end
        ST_DONE: begin
          state_q      <= ST_IDLE;
          resp_valid_q <= 1'b0;
          resp_error_q <= 1'b0;
          resp_rdata_q <= 32'h0000_0000;
          req_ready_q  <= 1'b1;
        end
        default: begin
          state_q      <= ST_IDLE;
          resp_valid_q <= 1'b0;
          resp_error_q <= 1'b0;
          mem_read_q   <= 1'b0;
          mem_write_q  <= 1'b0;
          req_ready_q  <= 1'b1;
        end
      endcase
    end
  end

  assign req_ready      = req_ready_q;
  assign resp_valid     = resp_valid_q;
  assign resp_rdata     = resp_rdata_q;
  assign resp_error     = resp_error_q;
  assign mem_address    = mem_address_q;
  assign mem_write_data = mem_write_data_q;
  assign MemRead        = mem_read_q;
  assign MemWrite       = mem_write_q;

endmodule

// File: tb/tb_load_store_unit.sv
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid1 = 1'b0;
  logic        req_valid3 = 1'b0;
  logic        req_store = 1'b0;
  logic [1:0]  req_size = 2'b00;
  logic        req_signed = 1'b0;
  logic [31:0] req_addr = 32'h0;
  logic [31:0] req_wdata = 32'h0;

  logic        rdy1, rv1, err1, mr1, mw1;
  logic [31:0] rd1, ma1, mwd1, mrd1;
  logic        rdy3, rv3, err3, mr3, mw3;
  logic [31:0] rd3, ma3, mwd3, mrd3;

  logic [31:0] mem1 [0:15];
  logic [31:0] mem3 [0:15];
  logic [7:0]  ref_b [0:63];

  logic        sel = 1'b0;
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  load_store_unit #(.ADDR_WIDTH(32), .READ_WAIT(1)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid1), .req_ready(rdy1),
    .req_store(req_store), .req_size(req_size), .req_signed(req_signed),
    .req_addr(req_addr), .req_wdata(req_wdata), .resp_valid(rv1),
    .resp_rdata(rd1), .resp_error(err1), .mem_address(ma1),
    .mem_write_data(mwd1), .MemRead(mr1), .MemWrite(mw1),
    .mem_read_data(mrd1));

  load_store_unit #(.ADDR_WIDTH(32), .READ_WAIT(3)) dut3 (
    .clk(clk), .reset(reset), .req_valid(req_valid3), .req_ready(rdy3),
    .req_store(req_store), .req_size(req_size), .req_signed(req_signed),
    .req_addr(req_addr), .req_wdata(req_wdata), .resp_valid(rv3),
    .resp_rdata(rd3), .resp_error(err3), .mem_address(ma3),
    .mem_write_data(mwd3), .MemRead(mr3), .MemWrite(mw3),
    .mem_read_data(mrd3));

  // Memory models: combinational read, write on the clock edge.
  assign mrd1 = mem1[ma1[5:2]];
  assign mrd3 = mem3[ma3[5:2]];
  always @(posedge clk) begin
    if (mw1) mem1[ma1[5:2]] <= mwd1;
    if (mw3) mem3[ma3[5:2]] <= mwd3;
  end

  // Observation muxes for whichever instance is under test.
  wire        o_rdy = sel ? rdy3 : rdy1;
  wire        o_rv  = sel ? rv3  : rv1;
  wire        o_err = sel ? err3 : err1;
  wire        o_mr  = sel ? mr3  : mr1;
  wire        o_mw  = sel ? mw3  : mw1;
  wire [31:0] o_rd  = sel ? rd3  : rd1;
  wire [31:0] o_ma  = sel ? ma3  : ma1;
  wire [31:0] o_mwd = sel ? mwd3 : mwd1;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_word(input int a);
    return {ref_b[a], ref_b[a+1], ref_b[a+2], ref_b[a+3]};
  endfunction

  // One request end to end; called at a negedge, returns at a negedge.
  task automatic do_req(input logic st, input logic [1:0] sz, input logic sg,
                        input int unsigned ad, input logic [31:0] wd, input bit poke);
    int nb, rw, exp_lat, exp_nrd, exp_nwr;
    int lat, nrd, nwr, both, addr_bad, ready_bad;
    bit legal, done;
    logic [31:0] exp_rd, exp_ww, obs_rd, obs_ww, exp_addr;
    logic [7:0]  v8;
    logic [15:0] v16;
    logic obs_err;
    nb = (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
    rw = sel ? 3 : 1;
    legal = (sz != 2'b11) && ((ad % nb) == 0);
    exp_rd = 32'h0; exp_ww = 32'h0; exp_nrd = 0; exp_nwr = 0;
    exp_addr = ad & 32'hFFFF_FFFC;
    if (!legal) begin
      exp_lat = 1;
    end else if (!st) begin
      exp_lat = 1 + rw; exp_nrd = rw;
      if (sz == 2'b00) begin
        v8 = ref_b[ad];
        exp_rd = sg ? 32'($signed(v8)) : 32'(v8);
      end else if (sz == 2'b01) begin
        v16 = {ref_b[ad], ref_b[ad+1]};
        exp_rd = sg ? 32'($signed(v16)) : 32'(v16);
      end else begin
        exp_rd = ref_word(ad);
      end
    end else begin
      exp_lat = (sz == 2'b10) ? 2 : 2 + rw;
      exp_nrd = (sz == 2'b10) ? 0 : rw;
      exp_nwr = 1;
      for (int i = 0; i < nb; i++) ref_b[ad+i] = wd[8*(nb-1-i) +: 8];
      exp_ww = ref_word(ad & ~3);
    end
    req_store = st; req_size = sz; req_signed = sg; req_addr = ad; req_wdata = wd;
    if (sel) req_valid3 = 1'b1; else req_valid1 = 1'b1;
    @(posedge clk); #1;
    req_valid1 = 1'b0; req_valid3 = 1'b0;
    lat = 0; nrd = 0; nwr = 0; both = 0; addr_bad = 0; ready_bad = 0; done = 0;
    obs_rd = 32'hDEAD_BEEF; obs_err = 1'bx; obs_ww = 32'hDEAD_BEEF;
    for (int c = 1; c <= 40 && !done; c++) begin
      @(negedge clk);
      if (c == 2) begin req_valid1 = 1'b0; req_valid3 = 1'b0; end
      if (o_mr) nrd++;
      if (o_mw) begin nwr++; obs_ww = o_mwd; end
      if (o_mr && o_mw) both++;
      if ((o_mr || o_mw) && (o_ma !== exp_addr)) addr_bad++;
      if (o_rdy !== 1'b0) ready_bad++;
      if (o_rv === 1'b1) begin
        lat = c; obs_rd = o_rd; obs_err = o_err; done = 1;
      end else if (c == 1 && poke) begin
        // Traffic while busy must be ignored, including payload changes.
        req_addr = $urandom_range(0, 63); req_wdata = $urandom;
        req_store = 1'($urandom); req_size = 2'($urandom);
        if (sel) req_valid3 = 1'b1; else req_valid1 = 1'b1;
      end
    end
    req_valid1 = 1'b0; req_valid3 = 1'b0;
    check("latency", lat, exp_lat);
    check("resp_error", obs_err, !legal);
    check("resp_rdata", obs_rd, exp_rd);
    check("memread_cycles", nrd, exp_nrd);
    check("memwrite_cycles", nwr, exp_nwr);
    check("rd_wr_overlap", both, 0);
    check("mem_address", addr_bad, 0);
    check("ready_while_busy", ready_bad, 0);
    if (exp_nwr == 1) check("mem_write_data", obs_ww, exp_ww);
    @(negedge clk);
    check("after_done", {o_rv, o_rdy}, 2'b01);
  endtask

  initial begin
    int unsigned a;
    for (int i = 0; i < 64; i++) ref_b[i] = 8'($urandom);
    ref_b[16] = 8'h89; ref_b[17] = 8'hAB; ref_b[18] = 8'hCD; ref_b[19] = 8'hEF;
    for (int i = 0; i < 16; i++) begin
      mem1[i] = ref_word(4*i);
      mem3[i] = ref_word(4*i);
    end

    // Reset state
    repeat (2) @(negedge clk);
    check("reset_state", {rdy1, rv1, rd1, err1, ma1, mwd1, mr1, mw1},
          {1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0});
    reset = 1'b0;
    @(negedge clk);
    check("ready_after_reset", rdy1, 1'b1);

    // READ_WAIT=3 instance: loads only, memory still pristine
    sel = 1'b1;
    do_req(1'b0, 2'b00, 1'b1, 32'h11, 32'h0, 0);
    do_req(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 1);
    sel = 1'b0;

    // Directed loads on word 0x10 = 0x89ABCDEF
    do_req(1'b0, 2'b00, 1'b1, 32'h11, 32'h0, 0);
    do_req(1'b0, 2'b00, 1'b0, 32'h13, 32'h0, 0);
    do_req(1'b0, 2'b01, 1'b1, 32'h10, 32'h0, 0);
    do_req(1'b0, 2'b01, 1'b0, 32'h12, 32'h0, 0);
    // Sub-word and word stores with read-back
    do_req(1'b1, 2'b00, 1'b0, 32'h12, 32'hFFFF_FF55, 0);
    do_req(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 0);
    do_req(1'b1, 2'b10, 1'b0, 32'h04, 32'h0123_4567, 0);
    do_req(1'b0, 2'b10, 1'b0, 32'h04, 32'h0, 0);
    // Error cases
    do_req(1'b0, 2'b10, 1'b0, 32'h06, 32'h0, 0);
    do_req(1'b0, 2'b01, 1'b1, 32'h03, 32'h0, 0);
    do_req(1'b0, 2'b11, 1'b0, 32'h08, 32'h0, 0);
    do_req(1'b1, 2'b01, 1'b0, 32'h05, 32'h1234_5678, 1);

    // Reset in the middle of a half store's READ
    req_store = 1'b1; req_size = 2'b01; req_signed = 1'b0;
    req_addr = 32'h10; req_wdata = 32'h0000_A5A5; req_valid1 = 1'b1;
    @(posedge clk); #1;
    req_valid1 = 1'b0;
    @(negedge clk);
    check("midreset_in_read", mr1, 1'b1);
    reset = 1'b1;
    #1;
    check("midreset_async", {rdy1, rv1, rd1, err1, ma1, mwd1, mr1, mw1},
          {1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0});
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    begin
      int stray = 0;
      for (int c = 0; c < 6; c++) begin
        @(negedge clk);
        if (mw1 !== 1'b0 || rv1 !== 1'b0 || rdy1 !== 1'b1) stray++;
      end
      check("midreset_quiet", stray, 0);
    end
    check("midreset_mem", mem1[4], ref_word(16));

    // Randomized traffic
    for (int n = 0; n < 40; n++) begin
      a = $urandom_range(0, 63);
      do_req(1'($urandom), 2'($urandom), 1'($urandom), a, $urandom,
             1'($urandom_range(0, 3) == 0));
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    // Final memory image
    for (int i = 0; i < 16; i++) check("mem_image", mem1[i], ref_word(4*i));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
